// File: rtl/ram512x8_arbiter_if.sv
// Bus bundle between the two word requesters, the arbiter and the byte RAM.
// Signal names keep the requester/RAM port naming used on the core side.
interface ram512x8_arbiter_if #(
    parameter int ADR_W = 7
);
    logic             a_req_i;
    logic             a_we_i;
    logic [ADR_W-1:0] a_adr_i;
    logic [3:0]       a_be_i;
    logic [31:0]      a_dat_i;
    logic [31:0]      a_dat_o;
    logic             a_ack_o;

    logic             b_req_i;
    logic             b_we_i;
    logic [ADR_W-1:0] b_adr_i;
    logic [3:0]       b_be_i;
    logic [31:0]      b_dat_i;
    logic [31:0]      b_dat_o;
    logic             b_ack_o;

    logic             ram_wen_o;
    logic [ADR_W+1:0] ram_adr_o;
    logic [7:0]       ram_dat_o;
    logic [7:0]       ram_dat_i;

    modport slave (
        input  a_req_i, a_we_i, a_adr_i, a_be_i, a_dat_i,
        output a_dat_o, a_ack_o,
        input  b_req_i, b_we_i, b_adr_i, b_be_i, b_dat_i,
        output b_dat_o, b_ack_o,
        output ram_wen_o, ram_adr_o, ram_dat_o,
        input  ram_dat_i
    );

    modport master (
        output a_req_i, a_we_i, a_adr_i, a_be_i, a_dat_i,
        input  a_dat_o, a_ack_o,
        output b_req_i, b_we_i, b_adr_i, b_be_i, b_dat_i,
        input  b_dat_o, b_ack_o,
        input  ram_wen_o, ram_adr_o, ram_dat_o,
        output ram_dat_i
    );
endinterface

// File: rtl/ram512x8_arbiter.sv
// Round-robin arbiter serialising two 32-bit word requesters onto one
// 512x8 RAM with registered read data (four byte cycles per word).
module ram512x8_arbiter #(
    parameter int ADR_W = 7
) (
    input logic                 clk_i,
    input logic                 rst_in,
    ram512x8_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             own_q, own_d;
    logic             last_q, last_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [31:0]      a_dat_q, a_dat_d;
    logic [31:0]      b_dat_q, b_dat_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    logic             wen_q, wen_d;
    logic [ADR_W+1:0] radr_q, radr_d;
    logic [7:0]       rwd_q, rwd_d;

    logic             grant_b;
    logic [1:0]       cnt_nx;
    logic [1:0]       cnt_pv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        a_dat_d = a_dat_q;
        b_dat_d = b_dat_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        wen_d   = 1'b0;
        radr_d  = radr_q;
        rwd_d   = rwd_q;
        // last_q = 1 means B was granted last, so A wins a tie
        grant_b = bus.b_req_i & (~bus.a_req_i | ~last_q);
        cnt_nx  = cnt_q + 2'd1;
        cnt_pv  = cnt_q - 2'd1;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req_i | bus.b_req_i) begin
                    state_d = XFER;
                    cnt_d   = 2'd0;
                    own_d   = grant_b;
                    last_d  = grant_b;
                    we_d    = grant_b ? bus.b_we_i  : bus.a_we_i;
                    adr_d   = grant_b ? bus.b_adr_i : bus.a_adr_i;
                    be_d    = grant_b ? bus.b_be_i  : bus.a_be_i;
                    wdat_d  = grant_b ? bus.b_dat_i : bus.a_dat_i;
                    radr_d  = {adr_d, 2'b00};
                    rwd_d   = wdat_d[7:0];
                    wen_d   = we_d & be_d[0];
                end
            end
            XFER: begin
                // byte cnt-1 is on ram_dat_i this cycle
                if (cnt_q != 2'd0) begin
                    rdat_d[{cnt_pv, 3'b000} +: 8] = bus.ram_dat_i;
                end
                if (cnt_q == 2'd3) begin
                    state_d = we_q ? ACK : WAIT;
                    a_ack_d = we_q & ~own_q;
                    b_ack_d = we_q & own_q;
                end else begin
                    cnt_d  = cnt_nx;
                    radr_d = {adr_q, cnt_nx};
                    rwd_d  = wdat_q[{cnt_nx, 3'b000} +: 8];
                    wen_d  = we_q & be_q[cnt_nx];
                end
            end
            WAIT: begin
                rdat_d[31:24] = bus.ram_dat_i;
                state_d       = ACK;
                a_ack_d       = ~own_q;
                b_ack_d       = own_q;
                if (own_q) begin
                    b_dat_d = rdat_d;
                end else begin
                    a_dat_d = rdat_d;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= '0;
            be_q    <= 4'd0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'd0;
            a_dat_q <= 32'd0;
            b_dat_q <= 32'd0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            wen_q   <= 1'b0;
            radr_q  <= '0;
            rwd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            a_dat_q <= a_dat_d;
            b_dat_q <= b_dat_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            wen_q   <= wen_d;
            radr_q  <= radr_d;
            rwd_q   <= rwd_d;
        end
    end

    // Reset kills the strobe in the same cycle so an aborted byte is not committed
    assign bus.ram_wen_o = wen_q & rst_in;
    assign bus.ram_adr_o = radr_q;
    assign bus.ram_dat_o = rwd_q;
    assign bus.a_dat_o   = a_dat_q;
    assign bus.b_dat_o   = b_dat_q;
    assign bus.a_ack_o   = a_ack_q;
    assign bus.b_ack_o   = b_ack_q;

endmodule

// File: tb/tb_ram512x8_arbiter.sv
// Scoreboard bench for ram512x8_arbiter with a behavioural 512x8 RAM
// whose read data is registered one cycle after the address.
module tb_ram512x8_arbiter;
    localparam int ADR_W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram512x8_arbiter_if #(.ADR_W(ADR_W)) bus ();

    ram512x8_arbiter #(.ADR_W(ADR_W)) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus.slave)
    );

    logic [7:0] mem [512];
    logic [7:0] rd_q;

    always @(posedge clk) begin
        if (bus.ram_wen_o === 1'b1) mem[bus.ram_adr_o] <= bus.ram_dat_o;
        rd_q <= mem[bus.ram_adr_o];
    end
    assign bus.ram_dat_i = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          who;
        logic [31:0] dat;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [8:0] adr;
        logic [7:0] dat;
        int         cyc;
    } wr_t;

    ack_t ackq[$];
    wr_t  wrq[$];
    ack_t ae;
    wr_t  we_e;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input bit who, input logic [31:0] d, input int c);
        ack_t a;
        a.who = who;
        a.dat = d;
        a.cyc = c;
        ackq.push_back(a);
    endtask

    task automatic push_wr(input logic [6:0] adr, input logic [3:0] be,
                           input logic [31:0] d, input int c0);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                wr_t w;
                w.adr = {adr, k[1:0]};
                w.dat = d[8*k +: 8];
                w.cyc = c0 + k;
                wrq.push_back(w);
            end
        end
    endtask

    task automatic wait_a(input int lim);
        int n = 0;
        while (bus.a_ack_o !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        if (bus.a_ack_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL a_timeout: no a_ack_o within %0d cycles", lim);
        end
        bus.a_req_i = 1'b0;
    endtask

    task automatic wait_b(input int lim);
        int n = 0;
        while (bus.b_ack_o !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        if (bus.b_ack_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL b_timeout: no b_ack_o within %0d cycles", lim);
        end
        bus.b_req_i = 1'b0;
    endtask

    // Monitor: every ack and every RAM write strobe is matched to the scoreboard
    always @(negedge clk) begin
        if (bus.a_ack_o === 1'b1 || bus.b_ack_o === 1'b1) begin
            if (ackq.size() == 0) begin
                chk("unexp_ack", {30'd0, bus.b_ack_o, bus.a_ack_o}, 32'd0);
            end else begin
                ae = ackq.pop_front();
                chk("ack_who", {30'd0, bus.b_ack_o, bus.a_ack_o},
                    ae.who ? 32'd2 : 32'd1);
                chk("ack_dat", ae.who ? bus.b_dat_o : bus.a_dat_o, ae.dat);
                chk("ack_cyc", cyc, ae.cyc);
            end
        end
        if (bus.ram_wen_o === 1'b1) begin
            if (wrq.size() == 0) begin
                chk("unexp_wr", {23'd0, bus.ram_adr_o}, 32'h1ff);
            end else begin
                we_e = wrq.pop_front();
                chk("wr_adr", {23'd0, bus.ram_adr_o}, {23'd0, we_e.adr});
                chk("wr_dat", {24'd0, bus.ram_dat_o}, {24'd0, we_e.dat});
                chk("wr_cyc", cyc, we_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int na;
        int nb;
        int n;
        logic [31:0] a_last;
        logic [31:0] b_last;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        a_last = 32'd0;
        b_last = 32'd0;

        // reset with both requesters already asking to write
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b1;
        bus.a_adr_i = 7'h05;
        bus.a_be_i  = 4'hF;
        bus.a_dat_i = 32'hDEADBEEF;
        bus.b_req_i = 1'b1;
        bus.b_we_i  = 1'b1;
        bus.b_adr_i = 7'h10;
        bus.b_be_i  = 4'hF;
        bus.b_dat_i = 32'hCAFEF00D;
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_a_ack", {31'd0, bus.a_ack_o}, 32'd0);
            chk("rst_b_ack", {31'd0, bus.b_ack_o}, 32'd0);
            chk("rst_wen", {31'd0, bus.ram_wen_o}, 32'd0);
            chk("rst_a_dat", bus.a_dat_o, 32'd0);
            chk("rst_b_dat", bus.b_dat_o, 32'd0);
        end
        rst_n = 1'b1;
        n0 = cyc;
        push_wr(7'h05, 4'hF, 32'hDEADBEEF, n0 + 1);
        push_ack(1'b0, a_last, n0 + 5);
        push_wr(7'h10, 4'hF, 32'hCAFEF00D, n0 + 7);
        push_ack(1'b1, b_last, n0 + 11);
        fork
            wait_a(30);
            wait_b(30);
        join
        tick();

        // A reads back its full word
        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b0;
        bus.a_adr_i = 7'h05;
        a_last = 32'hDEADBEEF;
        push_ack(1'b0, a_last, n0 + 6);
        wait_a(20);
        tick();

        // B partial write to bytes 1 and 2
        n0 = cyc;
        bus.b_req_i = 1'b1;
        bus.b_we_i  = 1'b1;
        bus.b_adr_i = 7'h05;
        bus.b_be_i  = 4'h6;
        bus.b_dat_i = 32'h11223344;
        push_wr(7'h05, 4'h6, 32'h11223344, n0 + 1);
        push_ack(1'b1, b_last, n0 + 5);
        wait_b(20);
        tick();

        // both hold reads: grants alternate A, B, A, B
        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b0;
        bus.a_adr_i = 7'h05;
        bus.b_req_i = 1'b1;
        bus.b_we_i  = 1'b0;
        bus.b_adr_i = 7'h10;
        push_ack(1'b0, 32'hDE2233EF, n0 + 6);
        push_ack(1'b1, 32'hCAFEF00D, n0 + 13);
        push_ack(1'b0, 32'hCAFEF00D, n0 + 20);
        push_ack(1'b1, 32'hDE2233EF, n0 + 27);
        na = 0;
        nb = 0;
        n = 0;
        while ((na < 2 || nb < 2) && n < 60) begin
            tick();
            n++;
            if (bus.a_ack_o === 1'b1) begin
                na++;
                if (na == 1) bus.a_adr_i = 7'h10;
                else bus.a_req_i = 1'b0;
            end
            if (bus.b_ack_o === 1'b1) begin
                nb++;
                if (nb == 1) bus.b_adr_i = 7'h05;
                else bus.b_req_i = 1'b0;
            end
        end
        if (na < 2 || nb < 2) begin
            total++;
            bad++;
            $display("FAIL rr_timeout: acks a=%0d b=%0d want 2 each", na, nb);
        end
        bus.a_req_i = 1'b0;
        bus.b_req_i = 1'b0;
        a_last = 32'hCAFEF00D;
        b_last = 32'hDE2233EF;
        tick();

        // A write while its inputs churn after grant
        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b1;
        bus.a_adr_i = 7'h20;
        bus.a_be_i  = 4'hF;
        bus.a_dat_i = 32'h55667788;
        push_wr(7'h20, 4'hF, 32'h55667788, n0 + 1);
        push_ack(1'b0, a_last, n0 + 5);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (bus.a_ack_o === 1'b1) break;
            bus.a_adr_i = 7'($urandom);
            bus.a_dat_i = $urandom;
            bus.a_be_i  = 4'($urandom);
        end
        if (bus.a_ack_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL stab_timeout: no a_ack_o within 20 cycles");
        end
        bus.a_req_i = 1'b0;
        tick();

        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b0;
        bus.a_adr_i = 7'h20;
        a_last = 32'h55667788;
        push_ack(1'b0, a_last, n0 + 6);
        wait_a(20);
        tick();

        // reset lands in the third byte cycle of a write
        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b1;
        bus.a_adr_i = 7'h05;
        bus.a_be_i  = 4'hF;
        bus.a_dat_i = 32'hA1B2C3D4;
        push_wr(7'h05, 4'h3, 32'hA1B2C3D4, n0 + 1);
        repeat (3) tick();
        rst_n = 1'b0;
        bus.a_req_i = 1'b0;
        tick();
        chk("abort_a_ack", {31'd0, bus.a_ack_o}, 32'd0);
        chk("abort_wen", {31'd0, bus.ram_wen_o}, 32'd0);
        chk("abort_a_dat", bus.a_dat_o, 32'd0);
        rst_n = 1'b1;
        a_last = 32'd0;
        repeat (3) tick();

        n0 = cyc;
        bus.a_req_i = 1'b1;
        bus.a_we_i  = 1'b0;
        bus.a_adr_i = 7'h05;
        push_ack(1'b0, 32'hDE22C3D4, n0 + 6);
        wait_a(20);
        repeat (2) tick();

        chk("ackq_left", ackq.size(), 32'd0);
        chk("wrq_left", wrq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
